systolic_sequencer: RTL and testbench

Job controller for the 2x2 int8 output-stationary systolic array. It accepts one job, an A (2xK) and B (Kx2) operand pair, through a valid/ready handshake. It clears the array accumulators, then streams the operands into the array edges with the required diagonal skew while driving the per-diagonal push enables. It captures the four 32-bit results and presents them on a valid/ready result port.

---
 rtl/systolic_sequencer.sv | 135 +++++++++++++
 tb/tb_systolic_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
// rtl/systolic_sequencer.sv - job sequencer for a 2x2 int8 output-stationary systolic array
module systolic_sequencer #(
  parameter int K      = 2,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [2*K*DATA_W-1:0]      a_mat,
  input  logic [K*2*DATA_W-1:0]      b_mat,
  output logic                       busy,
  output logic                       array_clr,
  output logic                       push11,
  output logic                       pushedge,
  output logic                       push22,
  output logic signed [DATA_W-1:0]   a1X,
  output logic signed [DATA_W-1:0]   a2X,
  output logic signed [DATA_W-1:0]   bX1,
  output logic signed [DATA_W-1:0]   bX2,
  input  logic signed [ACC_W-1:0]    c11,
  input  logic signed [ACC_W-1:0]    c12,
  input  logic signed [ACC_W-1:0]    c21,
  input  logic signed [ACC_W-1:0]    c22,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic signed [ACC_W-1:0]    res_c11,
  output logic signed [ACC_W-1:0]    res_c12,
  output logic signed [ACC_W-1:0]    res_c21,
  output logic signed [ACC_W-1:0]    res_c22
);

  localparam int CW = $clog2(K + 2);
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] K_C  = CW'(K);
  localparam logic [CW-1:0] K1_C = CW'(K + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t                    state, state_nx;
  logic [CW-1:0]             t;
  logic [IW-1:0]             t_i, tm1_i;
  logic                      clr_st;
  logic signed [DATA_W-1:0]  a_q [2][K];
  logic signed [DATA_W-1:0]  b_q [K][2];

  // Only the low bits are needed for indexing; out-of-range t is masked by the push terms.
  assign t_i   = t[IW-1:0];
  assign tm1_i = t_i - IW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      t     <= '0;
      for (int k = 0; k < K; k++) begin
        a_q[0][k] <= '0;
        a_q[1][k] <= '0;
        b_q[k][0] <= '0;
        b_q[k][1] <= '0;
      end
      res_c11 <= '0;
      res_c12 <= '0;
      res_c21 <= '0;
      res_c22 <= '0;
    end else begin
      state <= state_nx;
      t     <= (state == FEED && state_nx == FEED) ? t + CW'(1) : '0;
      if (state == IDLE && start_valid) begin
        for (int k = 0; k < K; k++) begin
          for (int i = 0; i < 2; i++) begin
            a_q[i][k] <= a_mat[(i*K+k)*DATA_W +: DATA_W];
            b_q[k][i] <= b_mat[(k*2+i)*DATA_W +: DATA_W];
          end
        end
      end
      if (state == DRAIN) begin
        res_c11 <= c11;
        res_c12 <= c12;
        res_c21 <= c21;
        res_c22 <= c22;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    start_ready = 1'b0;
    busy        = 1'b1;
    clr_st      = 1'b0;
    res_valid   = 1'b0;
    push11      = 1'b0;
    pushedge    = 1'b0;
    push22      = 1'b0;
    a1X         = '0;
    a2X         = '0;
    bX1         = '0;
    bX2         = '0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        if (start_valid) state_nx = CLEAR;
      end
      CLEAR: begin
        clr_st   = 1'b1;
        state_nx = FEED;
      end
      FEED: begin
        // Row/column 2 lag row/column 1 by one cycle to form the diagonal wavefront.
        push11   = (t < K_C);
        pushedge = (t != '0) && (t <= K_C);
        push22   = (t >= CW'(2)) && (t <= K1_C);
        if (push11) begin
          a1X = a_q[0][t_i];
          bX1 = b_q[t_i][0];
        end
        if (pushedge) begin
          a2X = a_q[1][tm1_i];
          bX2 = b_q[tm1_i][1];
        end
        if (t == K1_C) state_nx = DRAIN;
      end
      DRAIN: state_nx = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign array_clr = !reset || clr_st;

endmodule

// File: tb/tb_systolic_sequencer.sv
// tb/tb_systolic_sequencer.sv - directed-vector bench for systolic_sequencer
module tb_systolic_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   n_vec  = 0;
  int   n_miss = 0;

  // K=2 instance
  logic               sv2, sr2, busy2, clr2, p11_2, pe_2, p22_2, rv2, rr2;
  logic [31:0]        am2, bm2;
  logic signed [7:0]  a1_2, a2_2, b1_2, b2_2;
  logic signed [7:0]  ar11_2, br11_2, br12_2, ar21_2;
  logic signed [31:0] c2 [4];
  logic signed [31:0] r2 [4];

  // K=4 instance
  logic               sv4, sr4, busy4, clr4, p11_4, pe_4, p22_4, rv4, rr4;
  logic [63:0]        am4, bm4;
  logic signed [7:0]  a1_4, a2_4, b1_4, b2_4;
  logic signed [7:0]  ar11_4, br11_4, br12_4, ar21_4;
  logic signed [31:0] c4 [4];
  logic signed [31:0] r4 [4];

  systolic_sequencer #(.K(2), .DATA_W(8), .ACC_W(32)) dut2 (
    .clk(clk), .reset(reset), .start_valid(sv2), .start_ready(sr2),
    .a_mat(am2), .b_mat(bm2), .busy(busy2), .array_clr(clr2),
    .push11(p11_2), .pushedge(pe_2), .push22(p22_2),
    .a1X(a1_2), .a2X(a2_2), .bX1(b1_2), .bX2(b2_2),
    .c11(c2[0]), .c12(c2[1]), .c21(c2[2]), .c22(c2[3]),
    .res_valid(rv2), .res_ready(rr2),
    .res_c11(r2[0]), .res_c12(r2[1]), .res_c21(r2[2]), .res_c22(r2[3])
  );

  systolic_sequencer #(.K(4), .DATA_W(8), .ACC_W(32)) dut4 (
    .clk(clk), .reset(reset), .start_valid(sv4), .start_ready(sr4),
    .a_mat(am4), .b_mat(bm4), .busy(busy4), .array_clr(clr4),
    .push11(p11_4), .pushedge(pe_4), .push22(p22_4),
    .a1X(a1_4), .a2X(a2_4), .bX1(b1_4), .bX2(b2_4),
    .c11(c4[0]), .c12(c4[1]), .c21(c4[2]), .c22(c4[3]),
    .res_valid(rv4), .res_ready(rr4),
    .res_c11(r4[0]), .res_c12(r4[1]), .res_c21(r4[2]), .res_c22(r4[3])
  );

  // Behavioural 2x2 output-stationary array: operands hop right/down one PE per cycle.
  always @(posedge clk) begin
    if (clr2) begin
      for (int i = 0; i < 4; i++) c2[i] <= 0;
    end else begin
      if (p11_2) c2[0] <= c2[0] + a1_2 * b1_2;
      if (pe_2) begin
        c2[1] <= c2[1] + ar11_2 * b2_2;
        c2[2] <= c2[2] + a2_2 * br11_2;
      end
      if (p22_2) c2[3] <= c2[3] + ar21_2 * br12_2;
    end
    ar11_2 <= a1_2; br11_2 <= b1_2; br12_2 <= b2_2; ar21_2 <= a2_2;
  end

  always @(posedge clk) begin
    if (clr4) begin
      for (int i = 0; i < 4; i++) c4[i] <= 0;
    end else begin
      if (p11_4) c4[0] <= c4[0] + a1_4 * b1_4;
      if (pe_4) begin
        c4[1] <= c4[1] + ar11_4 * b2_4;
        c4[2] <= c4[2] + a2_4 * br11_4;
      end
      if (p22_4) c4[3] <= c4[3] + ar21_4 * br12_4;
    end
    ar11_4 <= a1_4; br11_4 <= b1_4; br12_4 <= b2_4; ar21_4 <= a2_4;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m2(input int x00, input int x01, input int x10, input int x11);
    return {x11[7:0], x10[7:0], x01[7:0], x00[7:0]};
  endfunction

  // Runs one K=2 job from IDLE (called at a negedge); hold = cycles of res_ready=0 in DONE.
  task automatic run2(input string nm, input logic [31:0] a, input logic [31:0] b,
                      input int e11, input int e12, input int e21, input int e22, input int hold);
    int n;
    int clr_cnt;
    check({nm, "_start_ready"}, sr2, 1);
    am2 = a; bm2 = b; sv2 = 1'b1; rr2 = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    sv2 = 1'b0; am2 = ~a; bm2 = ~b;
    n = 0; clr_cnt = 0;
    while (!rv2 && n < 40) begin
      if (clr2) clr_cnt++;
      if (n == 1) begin
        check({nm, "_t0_a2X"}, a2_2, 0);
        check({nm, "_t0_a1X"}, a1_2, $signed(a[7:0]));
        check({nm, "_t0_push11"}, p11_2, 1);
        check({nm, "_t0_pushedge"}, pe_2, 0);
      end
      if (n == 3) begin
        check({nm, "_t2_bX2"}, b2_2, $signed(b[31:24]));
        check({nm, "_t2_push22"}, p22_2, 1);
        check({nm, "_t2_push11"}, p11_2, 0);
      end
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, n, 6);
    check({nm, "_clr_cycles"}, clr_cnt, 1);
    check({nm, "_c11"}, r2[0], e11);
    check({nm, "_c12"}, r2[1], e12);
    check({nm, "_c21"}, r2[2], e21);
    check({nm, "_c22"}, r2[3], e22);
    if (hold > 0) begin
      sv2 = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({nm, "_hold_valid"}, rv2, 1);
        check({nm, "_hold_c11"}, r2[0], e11);
        check({nm, "_hold_c22"}, r2[3], e22);
        check({nm, "_hold_busy"}, busy2, 1);
        check({nm, "_hold_start_ready"}, sr2, 0);
      end
      sv2 = 1'b0;
      rr2 = 1'b1;
    end
    @(negedge clk);
    check({nm, "_post_valid"}, rv2, 0);
    check({nm, "_post_start_ready"}, sr2, 1);
    check({nm, "_post_busy"}, busy2, 0);
    rr2 = 1'b0;
  endtask

  initial begin
    int  n;
    int  p22_cnt;
    int  p22_first;
    bit  seen;
    reset = 1'b0;
    sv2 = 1'b0; rr2 = 1'b0; am2 = '0; bm2 = '0;
    sv4 = 1'b0; rr4 = 1'b0; am4 = '0; bm4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_start_ready", sr2, 1);
    check("rst_busy", busy2, 0);
    check("rst_res_valid", rv2, 0);
    check("rst_array_clr", clr2, 1);
    check("rst_res_c11", r2[0], 0);
    check("rst_push11", p11_2, 0);
    check("rst_a1X", a1_2, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_clr_released", clr2, 0);

    run2("basic", m2(1, 2, 3, 4), m2(5, 6, 7, 8), 19, 22, 43, 50, 0);
    run2("extreme", m2(-128, -128, 127, -1), m2(-128, 1, -128, -1), 32768, 0, -16128, 128, 0);
    run2("b2b_job1", m2(1, 2, 3, 4), m2(5, 6, 7, 8), 19, 22, 43, 50, 0);
    run2("b2b_job2", m2(1, 0, 0, 1), m2(9, -9, 3, 2), 9, -9, 3, 2, 0);
    run2("backpressure", m2(1, 2, 3, 4), m2(5, 6, 7, 8), 19, 22, 43, 50, 10);

    // Reset asserted at FEED t=1 aborts the job.
    am2 = m2(1, 2, 3, 4); bm2 = m2(5, 6, 7, 8); sv2 = 1'b1; rr2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv2 = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_at_t1_pushedge", pe_2, 1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy2, 0);
    check("abort_start_ready", sr2, 1);
    check("abort_push11", p11_2, 0);
    check("abort_pushedge", pe_2, 0);
    check("abort_a1X", a1_2, 0);
    check("abort_bX1", b1_2, 0);
    check("abort_array_clr", clr2, 1);
    check("abort_res_c11", r2[0], 0);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rv2) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    check("abort_clr_low", clr2, 0);
    rr2 = 1'b0;

    // K=4 job
    am4 = {8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'd4, 8'd3, 8'd2, 8'd1};
    bm4 = {8{8'd2}};
    sv4 = 1'b1; rr4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv4 = 1'b0;
    n = 0; p22_cnt = 0; p22_first = -1;
    while (!rv4 && n < 40) begin
      if (p22_4) begin
        p22_cnt++;
        if (p22_first < 0) p22_first = n;
      end
      @(negedge clk);
      n++;
    end
    check("k4_latency", n, 8);
    check("k4_push22_cycles", p22_cnt, 4);
    check("k4_push22_first", p22_first, 3);
    check("k4_c11", r4[0], 20);
    check("k4_c12", r4[1], 20);
    check("k4_c21", r4[2], -20);
    check("k4_c22", r4[3], -20);
    @(negedge clk);
    check("k4_post_start_ready", sr4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
